// File: rtl/ysyx_25040118_rf_pkg.sv
// Shared definitions for the multi-port register file: address width,
// address type and the architectural address validity check.
package ysyx_25040118_rf_pkg;

    localparam int AW = 5;

    typedef logic [AW-1:0] rf_addr_t;

    // x0 is hard-wired and addresses at or above the register count
    // (x16..x31 on RV32E) do not exist, so both are treated as invalid.
    function automatic logic addr_valid(input rf_addr_t addr, input int nreg);
        return (addr != '0) && (32'(addr) < 32'(nreg));
    endfunction

endpackage

// File: rtl/ysyx_25040118_rf_wsel.sv
// Write-port selector: for one lookup address, reports whether any write
// port targets it this cycle and, if so, the data of the highest-index
// such port (the port that also wins the array update).
module ysyx_25040118_rf_wsel
    import ysyx_25040118_rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int NWR  = 1
) (
    input  logic [AW-1:0]       i_addr,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    output logic                o_hit,
    output logic [XLEN-1:0]     o_data
);

    // Scan ports in ascending order so a later (higher-index) match overrides.
    // An invalid write address never matches, which also covers lookups of x0.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int p = 0; p < NWR; p++) begin
            if (i_wen[p] && addr_valid(i_waddr[p*AW +: AW], NREG) &&
                (i_waddr[p*AW +: AW] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_wdata[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ysyx_25040118_regfile_mp.sv
// Multi-port integer register file with a busy-bit scoreboard for
// issue-stage hazard detection. NRD combinational read ports, NWR
// synchronous write ports, optional same-cycle write-to-read bypass.
module ysyx_25040118_regfile_mp
    import ysyx_25040118_rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush
);

    // Internal index width: only the low bits of an address are used to
    // index storage, and only after the full address passed addr_valid.
    localparam int  IW  = $clog2(NREG);
    localparam logic BYP = (BYPASS != 0);

    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    logic [NWR-1:0]  w_wr_ok;
    logic [IW-1:0]   w_widx [NWR];

    logic            w_iss_ok;
    logic [IW-1:0]   w_iss_idx;
    logic            w_iss_hit;
    logic [XLEN-1:0] w_iss_data;
    logic            w_claim;

    // Decode which write ports are accepted and their storage index.
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            w_wr_ok[p] = wen[p] && addr_valid(waddr[p*AW +: AW], NREG);
            w_widx[p]  = waddr[p*AW +: IW];
        end
    end

    // Array update; later ports are applied last so port NWR-1 wins a collision.
    // Entry 0 is never written and stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (w_wr_ok[p]) begin
                    r_mem[w_widx[p]] <= wdata[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Claim check sees same-cycle writes so a completing producer frees its register.
    ysyx_25040118_rf_wsel #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NWR  (NWR)
    ) u_wsel_iss (
        .i_addr  (iss_rd),
        .i_wen   (wen),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .o_hit   (w_iss_hit),
        .o_data  (w_iss_data)
    );

    assign w_iss_ok  = addr_valid(iss_rd, NREG);
    assign w_iss_idx = iss_rd[IW-1:0];
    assign iss_ready = !(w_iss_ok && r_busy[w_iss_idx] && !(BYP && w_iss_hit));
    assign w_claim   = iss_valid && iss_ready && w_iss_ok;

    // Next busy vector: writes clear, then a claim sets (new owner wins),
    // then flush clears everything. Bit 0 is forced clear for x0.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWR; p++) begin
            if (w_wr_ok[p]) begin
                w_busy_nxt[w_widx[p]] = 1'b0;
            end
        end
        if (w_claim) begin
            w_busy_nxt[w_iss_idx] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector register; reset drops all pending claims.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports: zero for invalid addresses, bypassed write data when
    // enabled, else the stored value. rbusy is masked by a same-cycle write.
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic            w_ok;
        logic [IW-1:0]   w_idx;
        logic            w_hit;
        logic [XLEN-1:0] w_bdata;

        assign w_ok  = addr_valid(raddr[r*AW +: AW], NREG);
        assign w_idx = raddr[r*AW +: IW];

        ysyx_25040118_rf_wsel #(
            .XLEN (XLEN),
            .NREG (NREG),
            .NWR  (NWR)
        ) u_wsel_rd (
            .i_addr  (raddr[r*AW +: AW]),
            .i_wen   (wen),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .o_hit   (w_hit),
            .o_data  (w_bdata)
        );

        assign rdata[r*XLEN +: XLEN] = !w_ok           ? '0      :
                                       (BYP && w_hit)  ? w_bdata :
                                                         r_mem[w_idx];
        assign rbusy[r] = w_ok && r_busy[w_idx] && !(BYP && w_hit);
    end

`ifndef SYNTHESIS
    // Simulation hook mirroring the difftest register update: one call per
    // accepted write, with only the winning port reported on a collision.
    // The record {idx, value} and the running call count are kept so the
    // simulation environment can observe them.
    function automatic logic [AW+XLEN-1:0] npc_set_reg(input rf_addr_t idx,
                                                      input logic [XLEN-1:0] value);
        return {idx, value};
    endfunction

    logic [31:0]        w_dbg_calls;
    logic [AW+XLEN-1:0] w_dbg_last;
    logic [31:0]        r_dbg_calls;
    logic [AW+XLEN-1:0] r_dbg_last;

    // Collect this cycle's winning writes, skipping ports overridden by a higher one.
    always_comb begin
        logic v_win;
        v_win       = 1'b0;
        w_dbg_calls = '0;
        w_dbg_last  = r_dbg_last;
        for (int p = 0; p < NWR; p++) begin
            v_win = w_wr_ok[p];
            for (int q = p + 1; q < NWR; q++) begin
                if (w_wr_ok[q] && (waddr[q*AW +: AW] == waddr[p*AW +: AW])) begin
                    v_win = 1'b0;
                end
            end
            if (v_win) begin
                w_dbg_calls = w_dbg_calls + 32'd1;
                w_dbg_last  = npc_set_reg(waddr[p*AW +: AW], wdata[p*XLEN +: XLEN]);
            end
        end
    end

    // Accumulate hook calls on the same edge that commits the writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbg_calls <= '0;
            r_dbg_last  <= '0;
        end else begin
            r_dbg_calls <= r_dbg_calls + w_dbg_calls;
            r_dbg_last  <= w_dbg_last;
        end
    end
`endif

endmodule
